// File: rtl/uart_reg_ctrl.sv
// UART command controller: decodes framed write/read commands from a byte stream into
// register-bus strobes and returns ACK/NAK plus read data through the UART transmitter.
module uart_reg_ctrl #(
    parameter int DATA_BYTES   = 2,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_dv,
    input  logic [7:0]                rx_byte,
    output logic                      tx_dv,
    output logic [7:0]                tx_byte,
    input  logic                      tx_done,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [8*DATA_BYTES-1:0]   reg_wdata,
    output logic                      reg_we,
    output logic                      reg_re,
    input  logic [8*DATA_BYTES-1:0]   reg_rdata,
    input  logic                      reg_rvalid,
    output logic                      err
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int TW     = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52, ACK = 8'hA5, NAK = 8'h5A;

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, RX_DATA, EXEC_WR, EXEC_RD, WAIT_RD, TX_ACK, TX_DATA, TX_NAK
    } state_t;

    state_t              state_q, state_d;
    logic                is_rd_q, is_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          bcnt_q, bcnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                err_q, err_d;
    logic                tmo_hit, tx_fin, abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        bcnt_d    = bcnt_q;
        tmo_d     = '0;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        err_d     = 1'b0;
        abort     = 1'b0;
        tmo_hit   = (tmo_q == TW'(TIMEOUT_CLKS - 1));
        // tx_done is only meaningful once the strobe for the current byte has gone out
        tx_fin    = tx_done && !tx_dv_q;
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                        state_d = RX_ADDR;
                        is_rd_d = (rx_byte == OP_RD);
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            RX_ADDR: begin
                if (rx_dv) begin
                    addr_d  = rx_byte[ADDR_W-1:0];
                    bcnt_d  = '0;
                    state_d = is_rd_q ? EXEC_RD : RX_DATA;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (rx_dv) begin
                    wdata_d = DATA_W'({wdata_q, rx_byte});
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'(DATA_BYTES - 1)) state_d = EXEC_WR;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            EXEC_WR: begin
                state_d   = TX_ACK;
                tx_dv_d   = 1'b1;
                tx_byte_d = ACK;
            end
            EXEC_RD: state_d = WAIT_RD;
            WAIT_RD: begin
                if (reg_rvalid) begin
                    shift_d   = reg_rdata;
                    state_d   = TX_ACK;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = ACK;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            TX_ACK, TX_DATA: begin
                if (tx_fin) begin
                    if (!is_rd_q || (state_q == TX_DATA && bcnt_q == 3'(DATA_BYTES))) begin
                        state_d = IDLE;
                    end else begin
                        // bcnt counts data bytes already issued, MSB first from the shift reg
                        state_d   = TX_DATA;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = shift_q[DATA_W-1 -: 8];
                        shift_d   = DATA_W'({shift_q, 8'h00});
                        bcnt_d    = (state_q == TX_ACK) ? 3'd1 : bcnt_q + 3'd1;
                    end
                end
            end
            TX_NAK: if (tx_fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = TX_NAK;
            err_d     = 1'b1;
            tx_dv_d   = 1'b1;
            tx_byte_d = NAK;
        end
    end

    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = (state_q == EXEC_WR);
    assign reg_re    = (state_q == EXEC_RD);
    assign err       = err_q;
endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl: write/read frames, bad opcode, timeouts,
// bytes during a response and a mid-frame reset, with modelled UART TX and register bus.
module tb_uart_reg_ctrl;
    localparam int DB = 2;
    localparam int AW = 8;
    localparam int T  = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic [AW-1:0] reg_addr;
    logic [15:0]   reg_wdata;
    logic          reg_we, reg_re;
    logic [15:0]   reg_rdata;
    logic          reg_rvalid;
    logic          err;

    uart_reg_ctrl #(.DATA_BYTES(DB), .ADDR_W(AW), .TIMEOUT_CLKS(T)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int we_cnt = 0, re_cnt = 0, err_cnt = 0, both_cnt = 0;
    int we_cyc, re_cyc, err_cyc, rx_cyc;
    logic [AW-1:0] we_addr, re_addr;
    logic [15:0]   we_data;
    logic [7:0]    txq[$];
    int            txc[$];
    logic          rd_en;
    logic [15:0]   rd_val;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observers sample mid-cycle on the falling edge
    initial forever begin
        @(negedge clk);
        if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; we_cyc = cyc; end
        if (reg_re) begin re_cnt++; re_addr = reg_addr; re_cyc = cyc; end
        if (reg_we && reg_re) both_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (tx_dv) begin txq.push_back(tx_byte); txc.push_back(cyc); end
    end

    // Transmitter model: tx_done three cycles after each tx_dv
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Register bus model: reg_rvalid three cycles after reg_re
    initial begin
        reg_rvalid = 1'b0;
        reg_rdata  = '0;
        forever begin
            @(negedge clk);
            if (reg_re && rd_en) begin
                repeat (3) @(posedge clk);
                #1 reg_rvalid = 1'b1; reg_rdata = rd_val;
                @(posedge clk);
                #1 reg_rvalid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_dv = 1'b1; rx_byte = b; rx_cyc = cyc;
        @(posedge clk);
        #1 rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int we0, re0, err0, tx0, n;

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = '0; rd_en = 1'b1; rd_val = '0;
        idle(3);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_we_re", {reg_we, reg_re}, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        idle(2);

        // Write 0x57,0x10,0xBE,0xEF
        we0 = we_cnt; err0 = err_cnt; tx0 = txq.size();
        send(8'h57); send(8'h10); send(8'hBE); send(8'hEF);
        n = rx_cyc;
        idle(20);
        chk("wr_we_cnt", we_cnt - we0, 1);
        chk("wr_addr", we_addr, 8'h10);
        chk("wr_data", we_data, 16'hBEEF);
        chk("wr_we_cyc", we_cyc, n + 1);
        chk("wr_tx_cnt", txq.size() - tx0, 1);
        chk("wr_ack", txq[tx0], 8'hA5);
        chk("wr_ack_cyc", txc[tx0], n + 2);
        chk("wr_no_err", err_cnt - err0, 0);
        chk("wr_wdata_hold", reg_wdata, 16'hBEEF);

        // Read 0x52,0x22 returning 0x1234
        rd_val = 16'h1234; re0 = re_cnt; tx0 = txq.size();
        send(8'h52); send(8'h22);
        n = rx_cyc;
        idle(30);
        chk("rd_re_cnt", re_cnt - re0, 1);
        chk("rd_addr", re_addr, 8'h22);
        chk("rd_re_cyc", re_cyc, n + 1);
        chk("rd_tx_cnt", txq.size() - tx0, 3);
        chk("rd_b0", txq[tx0], 8'hA5);
        chk("rd_b1", txq[tx0+1], 8'h12);
        chk("rd_b2", txq[tx0+2], 8'h34);
        chk("rd_b0_cyc", txc[tx0], n + 5);
        chk("rd_b1_cyc", txc[tx0+1], n + 9);
        chk("rd_b2_cyc", txc[tx0+2], n + 13);

        // Bad opcode then a normal write
        we0 = we_cnt; re0 = re_cnt; err0 = err_cnt; tx0 = txq.size();
        send(8'h41);
        n = rx_cyc;
        idle(15);
        chk("bad_err_cnt", err_cnt - err0, 1);
        chk("bad_err_cyc", err_cyc, n + 1);
        chk("bad_nak", txq[tx0], 8'h5A);
        chk("bad_nak_cyc", txc[tx0], n + 1);
        chk("bad_no_bus", (we_cnt - we0) + (re_cnt - re0), 0);
        send(8'h57); send(8'h33); send(8'h12); send(8'h34);
        idle(20);
        chk("bad_then_wr", {we_addr, we_data}, {8'h33, 16'h1234});
        chk("bad_then_ack", txq[tx0+1], 8'hA5);

        // Inter-byte timeout after the first data byte
        we0 = we_cnt; err0 = err_cnt; tx0 = txq.size();
        send(8'h57); send(8'h10); send(8'hBE);
        n = rx_cyc;
        idle(80);
        chk("ito_err_cnt", err_cnt - err0, 1);
        chk("ito_err_cyc", err_cyc, n + T + 1);
        chk("ito_nak", txq[tx0], 8'h5A);
        chk("ito_nak_cyc", txc[tx0], n + T + 1);
        chk("ito_no_we", we_cnt - we0, 0);
        send(8'h57); send(8'h44); send(8'hCA); send(8'hFE);
        idle(20);
        chk("ito_then_wr", {we_cnt - we0, 8'(we_addr), we_data}, {32'(1), 8'h44, 16'hCAFE});

        // Read timeout: bus never answers
        rd_en = 1'b0; err0 = err_cnt; tx0 = txq.size();
        send(8'h52); send(8'h09);
        n = rx_cyc;
        idle(80);
        chk("rto_err_cyc", err_cyc, n + T + 2);
        chk("rto_tx_cnt", txq.size() - tx0, 1);
        chk("rto_nak", txq[tx0], 8'h5A);
        rd_en = 1'b1;

        // Bytes arriving during the response are ignored
        rd_val = 16'hC3D4; we0 = we_cnt; re0 = re_cnt; err0 = err_cnt; tx0 = txq.size();
        send(8'h52); send(8'h22);
        idle(5);
        send(8'h57); send(8'h41); send(8'h10);
        idle(30);
        chk("busy_tx_cnt", txq.size() - tx0, 3);
        chk("busy_bytes", {txq[tx0], txq[tx0+1], txq[tx0+2]}, {8'hA5, 8'hC3, 8'hD4});
        chk("busy_no_err", err_cnt - err0, 0);
        chk("busy_bus", {we_cnt - we0, re_cnt - re0}, {32'(0), 32'(1)});

        // Reset after the third byte of a write frame
        we0 = we_cnt; tx0 = txq.size();
        send(8'h57); send(8'h10); send(8'hAA);
        chk("pre_rst_wdata", reg_wdata, 16'hFEAA);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_outs", {tx_dv, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, err}, 0);
        idle(2);
        rst = 1'b0;
        idle(20);
        chk("mrst_no_we", we_cnt - we0, 0);
        chk("mrst_no_tx", txq.size() - tx0, 0);
        rd_val = 16'h0F0E; re0 = re_cnt;
        send(8'h52); send(8'h05);
        idle(30);
        chk("mrst_rd_addr", {re_cnt - re0, 8'(re_addr)}, {32'(1), 8'h05});
        chk("mrst_rd_bytes", {txq.size() - tx0, txq[tx0], txq[tx0+1], txq[tx0+2]},
            {32'(3), 8'hA5, 8'h0F, 8'h0E});

        chk("never_we_and_re", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_reg_ctrl.md
# uart_reg_ctrl

Parametrised UART command controller that turns a framed byte stream from the UART receiver into register-bus read/write transactions and returns acknowledge and read-data bytes through the UART transmitter. It sits between the `MBO_uart_rx`/`MBO_uart_tx` cores and any register bank or RAM in the MBO53 control path. It generalises the fixed 4-byte RAM access scheme with these additions:
- configurable data width;
- explicit read and write opcodes;
- ACK/NAK responses;
- inter-byte and read-response timeouts.

## Interface
Parameters:
- DATA_BYTES, 2: register data width in bytes (1..4); DATA_W = 8*DATA_BYTES.
- ADDR_W, 8: register address width (1..8); taken from the low ADDR_W bits of the address byte.
- TIMEOUT_CLKS, 200000: inter-byte and read-wait timeout in clk cycles (≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_dv  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- tx_dv  out  1  one-cycle strobe, start transmitting tx_byte
- tx_byte  out  8  byte to transmit; held stable from tx_dv until tx_done
- tx_done  in  1  one-cycle strobe, transmitter finished the byte
- reg_addr  out  ADDR_W  bus address
- reg_wdata  out  DATA_W  bus write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  DATA_W  read data, sampled when reg_rvalid=1
- reg_rvalid  in  1  read data valid; may be in the cycle after reg_re or later
- err  out  1  one-cycle pulse on any discarded frame

## Operation
- Frame format, all multi-byte fields MSB first:
  - Write: 0x57, ADDR, DATA_BYTES data bytes.
  - Read: 0x52, ADDR.
- Responses:
  - Write: ACK 0xA5.
  - Read: 0xA5 followed by DATA_BYTES bytes of reg_rdata, MSB first.
  - Error: NAK 0x5A.
- States:
  - IDLE:
    - rx_dv with 0x57 or 0x52 → RX_ADDR; the write/read flag is latched.
    - Any other byte → TX_NAK, with an err pulse.
  - RX_ADDR: on rx_dv, latch reg_addr <= rx_byte[ADDR_W-1:0].
    - Write → RX_DATA, with byte counter = 0.
    - Read → EXEC_RD.
  - RX_DATA: each rx_dv shifts the byte into the wdata shift register (wdata <= {wdata, rx_byte}) and increments the counter.
    - On the DATA_BYTES-th byte → EXEC_WR.
  - EXEC_WR: reg_we=1 for one cycle → TX_ACK.
  - EXEC_RD: reg_re=1 for one cycle → WAIT_RD.
  - WAIT_RD: on reg_rvalid, latch reg_rdata into the tx shift register → TX_ACK.
  - TX_ACK: send 0xA5.
    - Then → TX_DATA if the frame was a read.
    - Otherwise → IDLE.
  - TX_DATA: send DATA_BYTES bytes MSB first, then → IDLE.
  - TX_NAK: send 0x5A → IDLE.
- Transmit handshake:
  - tx_dv is pulsed exactly once per byte, on state entry or in the cycle after the previous tx_done.
  - The next byte is never issued before tx_done.
- Timeout: one counter, cleared on every rx_dv and on entry to WAIT_RD.
  - In RX_ADDR, RX_DATA or WAIT_RD, reaching TIMEOUT_CLKS discards the frame, pulses err and goes → TX_NAK.
  - The bus write is not performed on a timeout.
- rx_dv is ignored in every state except IDLE, RX_ADDR and RX_DATA; no buffering.
- reg_addr and reg_wdata hold their last values between transactions.

## Timing
- Reset values: tx_dv=0, tx_byte=0x00, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, err=0, state=IDLE, counters=0.
- rst asserted mid-frame or mid-response aborts immediately: no strobe is issued and tx_dv stays 0 until a new frame.
- Write path:
  - Last data byte's rx_dv at cycle N → reg_we=1 at N+1, with reg_wdata and reg_addr valid in that cycle.
  - tx_dv with 0xA5 at N+2.
- Read path:
  - ADDR rx_dv at cycle N → reg_re=1 at N+1.
  - reg_rvalid at cycle M → tx_dv with 0xA5 at M+1.
- Each subsequent tx byte's tx_dv comes exactly 1 cycle after the preceding tx_done.
- Invalid opcode rx_dv at N → err=1 at N+1 and tx_dv with 0x5A at N+1.
- Timeout fires when the counter equals TIMEOUT_CLKS-1. That is TIMEOUT_CLKS cycles with no rx_dv (or no reg_rvalid) → err and NAK tx_dv in the next cycle.
- If rx_dv and the timeout occur in the same cycle, rx_dv wins: the byte is accepted and the counter is cleared.
- reg_we and reg_re are never both asserted, and never asserted for more than one cycle per frame.

## Test plan
- Write (DATA_BYTES=2): bytes 0x57,0x10,0xBE,0xEF → one reg_we with reg_addr=0x10, reg_wdata=0xBEEF; tx 0xA5; err never asserted.
- Read: bytes 0x52,0x22; bus returns reg_rvalid 3 cycles after reg_re with 0x1234 → one reg_re, reg_addr=0x22; tx 0xA5,0x12,0x34 in order, each tx_dv 1 cycle after the previous tx_done.
- Bad opcode 0x41 → err pulse; tx 0x5A; no reg_we/reg_re; a following valid write frame completes normally.
- Inter-byte timeout (TIMEOUT_CLKS=50): 0x57,0x10,0xBE, then silence → err after 50 idle cycles, tx 0x5A, no reg_we; a fresh frame is then accepted.
- Read timeout: reg_rvalid never asserted → NAK after TIMEOUT_CLKS cycles.
- Bytes arriving during the response → ignored, with the response bytes unchanged.
- rst pulsed after the 3rd byte of a write frame → all outputs return to reset values at once; no reg_we; next 0x52,0x05 read is served correctly.
